qpsk_frame_deframer: RTL
========================

// Module: qpsk_frame_deframer
// PURPOSE
//  Sits directly downstream of the QPSK physical receiver. Consumes its dibit stream
//  (one symbol per in_valid pulse, 63-symbol frames after SOF) and packs it into bytes.
//  Stores each frame whole in an elastic buffer and commits it only when complete.
//  Emits committed frames on an AXI-Stream byte interface with tlast.
//  Upstream has no backpressure, so buffer overflow and stalled frames are resolved by dropping whole frames.
// PARAMETERS
//  FRAME_SYMS   63  symbols per frame; (FRAME_SYMS-HDR_SYMS) must be divisible by 4
//  HDR_SYMS     3   leading header symbols, forming a 6-bit sequence number
//  FIFO_DEPTH   64  byte-buffer entries; power of 2, >= 2*FRAME_BYTES
//  TIMEOUT_CYC  64  idle cycles inside a frame before the frame is aborted
//  FRAME_BYTES (derived) = 1 + (FRAME_SYMS-HDR_SYMS)/4 = 16
// PORTS
//  clk            in   1   system clock
//  aresetn        in   1   asynchronous active-low reset
//  in_valid       in   1   symbol strobe from the receiver (out_valid)
//  in_data        in   2   QPSK dibit from the receiver (out_data)
//  m_axis_tdata   out  8   output byte
//  m_axis_tvalid  out  1   output byte valid
//  m_axis_tready  in   1   downstream ready
//  m_axis_tlast   out  1   last byte of a frame
//  drop_cnt       out  16  frames dropped (overflow + timeout); saturating
//  busy           out  1   high while a frame is being collected or dropped
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all pointers and counters 0.
//   m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, drop_cnt=0, busy=0. Buffer contents are discarded.
//  FSM: IDLE / COLLECT / DROP.
//   IDLE: a symbol received (in_valid=1) is symbol 0 of a new frame.
//    If free space (DEPTH - (wr_ptr - rd_ptr)) >= FRAME_BYTES: go to COLLECT.
//    Otherwise: go to DROP and increment drop_cnt.
//   COLLECT/DROP: sym_cnt counts received symbols 0..FRAME_SYMS-1.
//    When symbol FRAME_SYMS-1 is received: go to IDLE.
//  Packing is MSB-first: the first dibit of a group lands in bits [7:6].
//   Header byte = {2'b00, d0, d1, d2}, with d0 in bits [5:4].
//   Written to the buffer on the edge that receives the last header symbol.
//   Each following 4-symbol group is written on the edge that receives its 4th symbol.
//   The final group (symbol 62) carries last=1 in the entry's tlast bit.
//  Commit: writes go to wr_ptr, which is private until commit.
//   On the edge writing the last byte, commit_ptr is set to wr_ptr+1.
//   m_axis_tvalid rises on the following cycle.
//   Abort (timeout) restores wr_ptr to commit_ptr, so no partial frame is ever visible.
//  Timeout: idle_cnt is cleared on every in_valid and increments otherwise while in COLLECT/DROP.
//   At idle_cnt == TIMEOUT_CYC-1 with no symbol:
//    COLLECT -> IDLE, roll back, drop_cnt+1.
//    DROP -> IDLE, with no additional drop_cnt increment.
//   A symbol arriving on the timeout cycle wins: no abort.
//  Output: show-ahead buffer.
//   m_axis_tvalid = (rd_ptr != commit_ptr); tdata/tlast are read from mem[rd_ptr].
//   rd_ptr advances on tvalid && tready.
//   tdata/tlast must remain stable while tvalid && !tready.
//  Pointers are log2(DEPTH)+1 bits wide and wrap naturally; full/empty use the extra MSB.
//  Simultaneous write and read in one cycle is supported.
//   Free space for the frame-start check uses the pre-edge rd_ptr (conservative).
//  drop_cnt saturates at 16'hFFFF. busy = (state != IDLE).
//  Back-to-back frames (in_valid every cycle) are sustained with no gap symbol required.
// TESTING
//  T1 single frame, header dibits 2,2,2 then payload 0,1,2,3 repeated, tready=1
//     -> 16 beats: 0x2A, then 15 x 0x1B; tlast only on beat 16; tvalid 1 cycle after symbol 62.
//  T2 tready=0, 5 frames sent at 8-cycle symbol spacing, DEPTH=64
//     -> frames 1-4 buffered, frame 5 dropped, drop_cnt=1, busy high during frame 5;
//        then tready=1 drains exactly 64 beats with 4 tlasts.
//  T3 30 symbols then 64 idle cycles -> no output beats, drop_cnt=1, busy falls;
//     next full frame is output intact (16 beats).
//  T4 symbol arrives exactly on idle cycle 63 -> no abort; frame completes normally, drop_cnt=0.
//  T5 aresetn pulsed low mid-frame with 1 committed frame pending -> tvalid=0 immediately;
//     drop_cnt=0; next frame output correctly.
//  T6 back-to-back frames with in_valid every cycle and random tready (50%)
//     -> byte stream matches the reference model, with no drops while occupancy allows.

Source files
------------

// File: rtl/qpsk_frame_deframer_if.sv
// Byte-wide AXI-Stream link carrying committed frames out of the deframer.
interface qpsk_frame_deframer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/qpsk_frame_deframer.sv
// Packs QPSK dibits into bytes, buffers whole frames and releases them on AXI-Stream
// only once complete; overflowing or stalled frames are dropped in their entirety.
module qpsk_frame_deframer #(
  parameter int FRAME_SYMS  = 63,
  parameter int HDR_SYMS    = 3,
  parameter int FIFO_DEPTH  = 64,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         in_valid,
  input  logic [1:0]                   in_data,
  qpsk_frame_deframer_if.master        m_axis,
  output logic [15:0]                  drop_cnt,
  output logic                         busy
);

  localparam int FRAME_BYTES = 1 + (FRAME_SYMS - HDR_SYMS) / 4;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int SCW = $clog2(FRAME_SYMS);
  localparam int ICW = $clog2(TIMEOUT_CYC);

  localparam logic [SCW-1:0] LAST_SYM      = SCW'(FRAME_SYMS - 1);
  localparam logic [SCW-1:0] HDR_LAST_SYM  = SCW'(HDR_SYMS - 1);
  localparam logic [SCW-1:0] HDR_SYMS_W    = SCW'(HDR_SYMS);
  localparam logic [1:0]     GRP_END_PHASE = 2'((HDR_SYMS + 3) % 4);
  localparam logic [ICW-1:0] IDLE_MAX      = ICW'(TIMEOUT_CYC - 1);
  localparam logic [PW:0]    DEPTH_W       = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]    FRAME_BYTES_W = (PW+1)'(FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

  state_t          state_q, state_d;
  logic [SCW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [5:0]      shift_q, shift_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [8:0]      mem [FIFO_DEPTH];
  logic            wr_en;
  logic            wr_last;
  logic [7:0]      wr_byte;
  logic            drop_inc;
  logic            out_valid;
  logic [PW-1:0]   used;
  logic [PW:0]     free_space;
  logic            hdr_end;
  logic            grp_end;

  assign out_valid  = (rd_ptr_q != commit_ptr_q);
  assign used       = wr_ptr_q - rd_ptr_q;
  assign free_space = DEPTH_W - {1'b0, used};
  assign hdr_end    = (sym_cnt_q == HDR_LAST_SYM);
  assign grp_end    = (sym_cnt_q >= HDR_SYMS_W) && (sym_cnt_q[1:0] == GRP_END_PHASE);
  assign wr_byte    = {shift_q, in_data};

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    shift_d      = shift_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_inc     = 1'b0;
    wr_en        = 1'b0;
    wr_last      = 1'b0;
    rd_ptr_d     = rd_ptr_q + PW'(out_valid && m_axis.tready);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sym_cnt_d  = SCW'(1);
          idle_cnt_d = '0;
          shift_d    = {4'b0000, in_data};
          if (free_space >= FRAME_BYTES_W) begin
            state_d = COLLECT;
          end else begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end
        end
      end
      COLLECT, DROP: begin
        if (in_valid) begin
          idle_cnt_d = '0;
          sym_cnt_d  = sym_cnt_q + SCW'(1);
          shift_d    = {shift_q[3:0], in_data};
          if (state_q == COLLECT && (hdr_end || grp_end)) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
          if (sym_cnt_q == LAST_SYM) begin
            state_d   = IDLE;
            sym_cnt_d = '0;
            if (state_q == COLLECT) begin
              wr_last      = 1'b1;
              commit_ptr_d = wr_ptr_q + PW'(1);
            end
          end
        end else if (idle_cnt_q == IDLE_MAX) begin
          // Roll back any uncommitted bytes; a frame already being dropped was counted on entry.
          state_d   = IDLE;
          sym_cnt_d = '0;
          wr_ptr_d  = commit_ptr_q;
          drop_inc  = (state_q == COLLECT);
        end else begin
          idle_cnt_d = idle_cnt_q + ICW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      sym_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      shift_q      <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {wr_last, wr_byte};
    end
  end

  // Gate the show-ahead read so stale buffer contents never appear on the bus.
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? mem[rd_ptr_q[AW-1:0]][7:0] : 8'h00;
  assign m_axis.tlast  = out_valid ? mem[rd_ptr_q[AW-1:0]][8]   : 1'b0;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = (state_q != IDLE);

endmodule
